// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART-fed ALU path: opcode encodings and controller states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: OP_* opcodes (also decoded by the ALU), ST_* controller state encodings,
//           is_valid_op() opcode membership check.
package alu_uart_pkg;

   localparam int OP_W    = 6;
   localparam int STATE_W = 3;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

   localparam logic [STATE_W-1:0] ST_GET_A  = 3'd0;
   localparam logic [STATE_W-1:0] ST_GET_B  = 3'd1;
   localparam logic [STATE_W-1:0] ST_GET_OP = 3'd2;
   localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
   localparam logic [STATE_W-1:0] ST_SEND   = 3'd4;

   function automatic logic is_valid_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
         default:                        is_valid_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_uart_ctrl_timeout_counter.sv
// Saturating idle-cycle counter; flags expiry on the LIMIT-th consecutive enabled cycle.
// Latency: o_expired is combinational from the count and i_enable (no dependence on i_clear).
// Backpressure: none; counts while enabled, holds otherwise, clear wins over enable.
// Ports: i_clk, i_reset (sync, active-high), i_clear (zero next edge),
//        i_enable (count this cycle), o_expired (this enabled cycle is the LIMIT-th).
module timeout_counter #(
   parameter int LIMIT = 100000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_enable && (cnt_q != CNT_MAX)) begin
         // Stops at LIMIT so a stuck enable can never wrap back to zero.
         cnt_d = cnt_q + CW'(1);
      end
   end

   // cnt_q already holds LIMIT-1 idle cycles, so this enabled cycle is the LIMIT-th.
   assign o_expired = i_enable && (cnt_q >= CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Frames RX bytes (A, B, opcode) into ALU operands and pushes the ALU result to the TX FIFO.
// Latency: last RX pop to TX push is 2 cycles (one EXEC cycle, then SEND) when TX is not full.
// Backpressure: RX popped only when non-empty; SEND holds with o_tx_data stable while i_tx_full.
// Ports: i_clk, i_reset (sync, active-high); RX FIFO i_rx_empty/i_rx_data/o_rx_read;
//        TX FIFO i_tx_full/o_tx_write/o_tx_data; ALU o_alu_a/o_alu_b/o_alu_op/i_alu_result;
//        status o_busy, o_op_error, o_timeout (single-cycle pulses).
module alu_uart_ctrl
   import alu_uart_pkg::*;
#(
   parameter int NB_DATA        = 8,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_empty,
   input  logic [NB_DATA-1:0] i_rx_data,
   output logic               o_rx_read,
   input  logic               i_tx_full,
   output logic               o_tx_write,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic               o_busy,
   output logic               o_op_error,
   output logic               o_timeout
);

   logic [STATE_W-1:0] state_q,    state_d;
   logic [NB_DATA-1:0] alu_a_q,    alu_a_d;
   logic [NB_DATA-1:0] alu_b_q,    alu_b_d;
   logic [NB_OP-1:0]   alu_op_q,   alu_op_d;
   logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
   logic               op_error_q, op_error_d;
   logic               timeout_q,  timeout_d;

   // Pop/push strobes must coincide with the FIFO flags of the same cycle, so they
   // are decoded from registered state plus the live flag rather than delayed a cycle.
   logic rx_read;
   logic tx_write;

   logic tmo_enable;
   logic tmo_clear;
   logic tmo_expired;

   assign tmo_enable = ((state_q == ST_GET_B) || (state_q == ST_GET_OP)) && i_rx_empty;
   assign tmo_clear  = (state_d != state_q);

   timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_counter (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (tmo_clear),
      .i_enable  (tmo_enable),
      .o_expired (tmo_expired)
   );

   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      tx_data_d  = tx_data_q;
      op_error_d = 1'b0;
      timeout_d  = 1'b0;
      rx_read    = 1'b0;
      tx_write   = 1'b0;

      case (state_q)
         ST_GET_A: begin
            if (!i_rx_empty) begin
               alu_a_d = i_rx_data;
               rx_read = 1'b1;
               state_d = ST_GET_B;
            end
         end
         ST_GET_B: begin
            if (!i_rx_empty) begin
               alu_b_d = i_rx_data;
               rx_read = 1'b1;
               state_d = ST_GET_OP;
            end else if (tmo_expired) begin
               timeout_d = 1'b1;
               state_d   = ST_GET_A;
            end
         end
         ST_GET_OP: begin
            if (!i_rx_empty) begin
               alu_op_d = i_rx_data[NB_OP-1:0];
               rx_read  = 1'b1;
               if (is_valid_op(OP_W'(i_rx_data[NB_OP-1:0]))) begin
                  state_d = ST_EXEC;
               end else begin
                  op_error_d = 1'b1;
                  state_d    = ST_GET_A;
               end
            end else if (tmo_expired) begin
               timeout_d = 1'b1;
               state_d   = ST_GET_A;
            end
         end
         ST_EXEC: begin
            tx_data_d = i_alu_result;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            if (!i_tx_full) begin
               tx_write = 1'b1;
               state_d  = ST_GET_A;
            end
         end
         default: begin
            state_d = ST_GET_A;
         end
      endcase

      // Reset wins: nothing may be popped or pushed in the reset cycle.
      if (i_reset) begin
         rx_read  = 1'b0;
         tx_write = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_GET_A;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         op_error_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         tx_data_q  <= tx_data_d;
         op_error_q <= op_error_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_rx_read  = rx_read;
   assign o_tx_write = tx_write;
   assign o_tx_data  = tx_data_q;
   assign o_alu_a    = alu_a_q;
   assign o_alu_b    = alu_b_q;
   assign o_alu_op   = alu_op_q;
   assign o_busy     = (state_q != ST_GET_A);
   assign o_op_error = op_error_q;
   assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: RX FIFO model, reference ALU, table of frames plus
// hand sequences for TX backpressure, idle timeout and mid-frame reset.
module tb_alu_uart_ctrl;

   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;
   localparam int TMO     = 16;

   logic               clk = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_rx_empty = 1'b1;
   logic [NB_DATA-1:0] i_rx_data = '0;
   logic               o_rx_read;
   logic               i_tx_full = 1'b0;
   logic               o_tx_write;
   logic [NB_DATA-1:0] o_tx_data;
   logic [NB_DATA-1:0] o_alu_a, o_alu_b;
   logic [NB_OP-1:0]   o_alu_op;
   logic [NB_DATA-1:0] i_alu_result;
   logic               o_busy, o_op_error, o_timeout;

   always #5 clk = ~clk;

   alu_uart_ctrl #(
      .NB_DATA        (NB_DATA),
      .NB_OP          (NB_OP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_rx_empty   (i_rx_empty),
      .i_rx_data    (i_rx_data),
      .o_rx_read    (o_rx_read),
      .i_tx_full    (i_tx_full),
      .o_tx_write   (o_tx_write),
      .o_tx_data    (o_tx_data),
      .o_alu_a      (o_alu_a),
      .o_alu_b      (o_alu_b),
      .o_alu_op     (o_alu_op),
      .i_alu_result (i_alu_result),
      .o_busy       (o_busy),
      .o_op_error   (o_op_error),
      .o_timeout    (o_timeout)
   );

   // Reference ALU (external to the controller).
   logic signed [NB_DATA-1:0] sa;
   always_comb begin
      sa = o_alu_a;
      case (o_alu_op)
         6'b100000: i_alu_result = o_alu_a + o_alu_b;
         6'b100010: i_alu_result = o_alu_a - o_alu_b;
         6'b100100: i_alu_result = o_alu_a & o_alu_b;
         6'b100101: i_alu_result = o_alu_a | o_alu_b;
         6'b100110: i_alu_result = o_alu_a ^ o_alu_b;
         6'b100111: i_alu_result = ~(o_alu_a | o_alu_b);
         6'b000011: i_alu_result = sa >>> o_alu_b;
         6'b000010: i_alu_result = o_alu_a >> o_alu_b;
         default:   i_alu_result = '0;
      endcase
   end

   logic [NB_DATA-1:0] rx_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic pop_seen, wr_seen, err_seen, tmo_seen, busy_seen;
   logic [NB_DATA-1:0] wdata_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_rx();
      i_rx_empty = (rx_q.size() == 0);
      i_rx_data  = (rx_q.size() == 0) ? '0 : rx_q[0];
   endtask

   // Sample on the falling edge, let the rising edge act, then update inputs 1ns later.
   task automatic tick();
      @(negedge clk);
      pop_seen   = o_rx_read;
      wr_seen    = o_tx_write;
      wdata_seen = o_tx_data;
      err_seen   = o_op_error;
      tmo_seen   = o_timeout;
      busy_seen  = o_busy;
      check("rx_read_while_empty", {31'd0, o_rx_read && i_rx_empty}, 32'd0);
      check("tx_write_while_full", {31'd0, o_tx_write && i_tx_full}, 32'd0);
      @(posedge clk);
      cyc++;
      if (pop_seen && rx_q.size() != 0) void'(rx_q.pop_front());
      #1;
      drive_rx();
   endtask

   task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [5:0] op, input logic ok, input logic [7:0] res);
      int pops, wrs, errs, tmos, last_pop, wr_cyc;
      logic [7:0] wd;
      pops = 0; wrs = 0; errs = 0; tmos = 0; last_pop = -100; wr_cyc = -1; wd = '0;
      rx_q.push_back(a);
      rx_q.push_back(b);
      rx_q.push_back({2'b00, op});
      drive_rx();
      repeat (12) begin
         tick();
         if (pop_seen) begin pops++; last_pop = cyc; end
         if (wr_seen)  begin wrs++;  wr_cyc = cyc; wd = wdata_seen; end
         if (err_seen) errs++;
         if (tmo_seen) tmos++;
      end
      check({name, "_pops"}, pops, 3);
      check({name, "_timeouts"}, tmos, 0);
      check({name, "_idle_after"}, {31'd0, busy_seen}, 32'd0);
      if (ok) begin
         check({name, "_writes"}, wrs, 1);
         check({name, "_data"}, {24'd0, wd}, {24'd0, res});
         check({name, "_latency"}, wr_cyc - last_pop, 2);
         check({name, "_op_error"}, errs, 0);
      end else begin
         check({name, "_writes"}, wrs, 0);
         check({name, "_op_error"}, errs, 1);
      end
   endtask

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic       ok;
      logic [7:0] res;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int n, t_pop, t_tmo, wrs;
      vecs[0]  = '{"add_5_3",    8'h05, 8'h03, 6'h20, 1'b1, 8'h08};
      vecs[1]  = '{"bad_op_3f",  8'h01, 8'h02, 6'h3F, 1'b0, 8'h00};
      vecs[2]  = '{"sub_a_4",    8'h0A, 8'h04, 6'h22, 1'b1, 8'h06};
      vecs[3]  = '{"or_f0_0f",   8'hF0, 8'h0F, 6'h25, 1'b1, 8'hFF};
      vecs[4]  = '{"and_cc_aa",  8'hCC, 8'hAA, 6'h24, 1'b1, 8'h88};
      vecs[5]  = '{"xor_cc_aa",  8'hCC, 8'hAA, 6'h26, 1'b1, 8'h66};
      vecs[6]  = '{"nor_cc_aa",  8'hCC, 8'hAA, 6'h27, 1'b1, 8'h11};
      vecs[7]  = '{"sra_80_3",   8'h80, 8'h03, 6'h03, 1'b1, 8'hF0};
      vecs[8]  = '{"srl_80_3",   8'h80, 8'h03, 6'h02, 1'b1, 8'h10};
      vecs[9]  = '{"sub_wrap",   8'h03, 8'h05, 6'h22, 1'b1, 8'hFE};
      vecs[10] = '{"add_trunc",  8'hFF, 8'h02, 6'h20, 1'b1, 8'h01};

      // Reset state.
      i_reset = 1'b1;
      tick(); tick();
      check("rst_busy",     {31'd0, o_busy},     32'd0);
      check("rst_tx_data",  {24'd0, o_tx_data},  32'd0);
      check("rst_alu_a",    {24'd0, o_alu_a},    32'd0);
      check("rst_alu_op",   {26'd0, o_alu_op},   32'd0);
      check("rst_op_error", {31'd0, o_op_error}, 32'd0);
      check("rst_timeout",  {31'd0, o_timeout},  32'd0);
      i_reset = 1'b0;

      // Table of frames; the invalid opcode frame is followed by a normal one.
      for (int i = 0; i < 11; i++)
         run_frame(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ok, vecs[i].res);
      check("operands_held_a", {24'd0, o_alu_a}, 32'h0000_00FF);
      check("operands_held_op", {26'd0, o_alu_op}, 32'h0000_0020);

      // TX backpressure: SUB 9-4 with TX full for 25 cycles, then released.
      i_tx_full = 1'b1;
      rx_q.push_back(8'h09); rx_q.push_back(8'h04); rx_q.push_back(8'h22);
      drive_rx();
      wrs = 0; n = 0;
      repeat (25) begin
         tick();
         if (wr_seen) wrs++;
         if (tmo_seen) n++;
      end
      check("full_no_write", wrs, 0);
      check("full_no_timeout", n, 0);
      check("full_busy", {31'd0, busy_seen}, 32'd1);
      check("full_data_held", {24'd0, wdata_seen}, 32'h0000_0005);
      i_tx_full = 1'b0;
      tick();
      check("full_release_write", {31'd0, wr_seen}, 32'd1);
      check("full_release_data", {24'd0, wdata_seen}, 32'h0000_0005);
      tick();
      check("full_release_idle", {31'd0, busy_seen}, 32'd0);

      // No timeout while waiting for A.
      n = 0;
      repeat (40) begin tick(); if (tmo_seen) n++; end
      check("get_a_no_timeout", n, 0);

      // Timeout: only A arrives; pulse seen after 16 idle GET_B cycles (registered).
      rx_q.push_back(8'h11);
      drive_rx();
      tick();
      check("tmo_pop_a", {31'd0, pop_seen}, 32'd1);
      t_pop = cyc; t_tmo = -1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (tmo_seen) begin t_tmo = cyc; break; end
      end
      check("tmo_delay", t_tmo - t_pop, TMO + 1);
      tick();
      check("tmo_pulse_width", {31'd0, tmo_seen}, 32'd0);
      check("tmo_idle", {31'd0, busy_seen}, 32'd0);
      run_frame("after_tmo", 8'hF0, 8'h0F, 6'h25, 1'b1, 8'hFF);

      // Reset while waiting in GET_OP with the opcode byte arriving the same cycle.
      rx_q.push_back(8'h33); rx_q.push_back(8'h44);
      drive_rx();
      tick(); tick(); tick();
      check("rst_mid_busy_before", {31'd0, busy_seen}, 32'd1);
      rx_q.push_back(8'h20);
      drive_rx();
      i_reset = 1'b1;
      tick();
      check("rst_mid_no_pop", {31'd0, pop_seen}, 32'd0);
      check("rst_mid_no_write", {31'd0, wr_seen}, 32'd0);
      rx_q.delete();
      drive_rx();
      tick();
      check("rst_mid_busy", {31'd0, busy_seen}, 32'd0);
      check("rst_mid_alu_a", {24'd0, o_alu_a}, 32'd0);
      check("rst_mid_alu_b", {24'd0, o_alu_b}, 32'd0);
      i_reset = 1'b0;
      run_frame("after_rst", 8'h07, 8'h02, 6'h20, 1'b1, 8'h09);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
